// File: rtl/md_unit_pkg.sv
// md_unit_pkg
//   Shared definitions for the multiply/divide unit: MDOp encodings (also
//   used by the decoder and hazard unit), default latencies, and the
//   sequencer state type.
package md_unit_pkg;

  // MDOp encodings; 6 and 7 are reserved and behave as no-ops.
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // Default latencies: edges from accept until HI/LO are written.
  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } mdState_t;

  function automatic int mdMax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith
//   Combinational arithmetic core for the multiply/divide unit.
//   Ports:
//     op      - MDOp code
//     a, b    - rs / rt operands
//     resHi   - product high word, or remainder for DIV/DIVU
//     resLo   - product low word, or quotient for DIV/DIVU
//     divZero - divisor is zero (HI/LO must not be written)
module md_arith
  import md_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] resHi,
  output logic [31:0] resLo,
  output logic        divZero
);

  logic signed [63:0] aExt;
  logic signed [63:0] bExt;
  logic signed [63:0] sProd;
  logic        [63:0] uProd;
  logic        [31:0] bSafe;
  logic               sOverflow;

  // Explicit sign extension keeps the signed product independent of
  // context-width rules.
  assign aExt  = {{32{a[31]}}, a};
  assign bExt  = {{32{b[31]}}, b};
  assign sProd = aExt * bExt;
  assign uProd = {32'd0, a} * {32'd0, b};

  assign divZero = (b == 32'd0);
  // Never divide by zero in hardware; the result is discarded anyway.
  assign bSafe   = divZero ? 32'd1 : b;
  // -2^31 / -1 overflows the 32-bit quotient; the architected answer is
  // quotient 0x80000000, remainder 0, handled explicitly.
  assign sOverflow = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  always_comb begin
    resHi = 32'd0;
    resLo = 32'd0;
    case (op)
      MD_MULT: begin
        resHi = sProd[63:32];
        resLo = sProd[31:0];
      end
      MD_MULTU: begin
        resHi = uProd[63:32];
        resLo = uProd[31:0];
      end
      MD_DIV: begin
        if (sOverflow) begin
          resHi = 32'd0;
          resLo = 32'h8000_0000;
        end else begin
          // SV signed / and % truncate toward zero; remainder follows the
          // dividend's sign.
          resLo = $signed(a) / $signed(bSafe);
          resHi = $signed(a) % $signed(bSafe);
        end
      end
      MD_DIVU: begin
        resLo = a / bSafe;
        resHi = a % bSafe;
      end
      default: begin
        resHi = 32'd0;
        resLo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit
//   EX-stage multiply/divide unit owning the architectural HI/LO registers.
//   The result is computed at accept into pending registers and committed
//   after a fixed latency.
//   Ports:
//     clk, reset - core clock, synchronous active-high reset
//     En, MDOp   - mult/div/mthi/mtlo request and its operation code
//     Cancel     - exception this cycle; suppresses En (in-flight op continues)
//     A, B       - forwarded rs / rt operands
//     Busy       - operation in flight
//     HI, LO     - architectural HI/LO
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        En,
  input  logic [2:0]  MDOp,
  input  logic        Cancel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  // The counter holds at most N-1, so clog2(N) bits suffice.
  localparam int CNT_MAX = mdMax(MULT_CYCLES, DIV_CYCLES);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  mdState_t    stateReg, stateNext;
  logic [CW-1:0] countReg, countNext;
  logic [31:0] pendHiReg, pendHiNext;
  logic [31:0] pendLoReg, pendLoNext;
  logic        pendWrReg, pendWrNext;
  logic [31:0] hiReg, hiNext;
  logic [31:0] loReg, loNext;

  logic [31:0] resHi, resLo;
  logic        divZero;
  logic        accept;

  md_arith uArith (
    .op      (MDOp),
    .a       (A),
    .b       (B),
    .resHi   (resHi),
    .resLo   (resLo),
    .divZero (divZero)
  );

  assign accept = En && !Cancel && (stateReg == MD_IDLE);

  always_comb begin
    stateNext  = stateReg;
    countNext  = countReg;
    pendHiNext = pendHiReg;
    pendLoNext = pendLoReg;
    pendWrNext = pendWrReg;
    hiNext     = hiReg;
    loNext     = loReg;
    case (stateReg)
      MD_IDLE: begin
        if (accept) begin
          case (MDOp)
            MD_MULT, MD_MULTU: begin
              stateNext  = MD_RUN;
              countNext  = CW'(MULT_CYCLES - 1);
              pendHiNext = resHi;
              pendLoNext = resLo;
              pendWrNext = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
              stateNext  = MD_RUN;
              countNext  = CW'(DIV_CYCLES - 1);
              pendHiNext = resHi;
              pendLoNext = resLo;
              // Divide by zero still takes the full latency but commits nothing.
              pendWrNext = !divZero;
            end
            MD_MTHI: hiNext = A;
            MD_MTLO: loNext = A;
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        if (countReg == '0) begin
          stateNext = MD_IDLE;
          if (pendWrReg) begin
            hiNext = pendHiReg;
            loNext = pendLoReg;
          end
        end else begin
          countNext = countReg - 1'b1;
        end
      end
      default: stateNext = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg  <= MD_IDLE;
      countReg  <= '0;
      pendHiReg <= 32'd0;
      pendLoReg <= 32'd0;
      pendWrReg <= 1'b0;
      hiReg     <= 32'd0;
      loReg     <= 32'd0;
    end else begin
      stateReg  <= stateNext;
      countReg  <= countNext;
      pendHiReg <= pendHiNext;
      pendLoReg <= pendLoNext;
      pendWrReg <= pendWrNext;
      hiReg     <= hiNext;
      loReg     <= loNext;
    end
  end

  assign Busy = (stateReg == MD_RUN);
  assign HI   = hiReg;
  assign LO   = loReg;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        En = 1'b0;
  logic [2:0]  MDOp = 3'd0;
  logic        Cancel = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy;
  logic [31:0] HI, LO;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .En(En), .MDOp(MDOp), .Cancel(Cancel),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int busyCount = 0;
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  // Reference model: architectural result of one accepted operation.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output int cyc);
    longint x, y, qt, rm, p;
    logic [63:0] up;
    hi = mHi; lo = mLo; cyc = 0;
    case (op)
      3'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        hi = p[63:32]; lo = p[31:0]; cyc = MULT_N;
      end
      3'd1: begin
        up = {32'd0, a} * {32'd0, b};
        hi = up[63:32]; lo = up[31:0]; cyc = MULT_N;
      end
      3'd2: begin
        cyc = DIV_N;
        if (b != 0) begin
          x = longint'($signed(a)); y = longint'($signed(b));
          qt = x / y; rm = x % y;
          lo = qt[31:0]; hi = rm[31:0];
        end
      end
      3'd3: begin
        cyc = DIV_N;
        if (b != 0) begin
          x = longint'({32'd0, a}); y = longint'({32'd0, b});
          qt = x / y; rm = x % y;
          lo = qt[31:0]; hi = rm[31:0];
        end
      end
      3'd4: hi = a;
      3'd5: lo = a;
      default: ;
    endcase
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 40 && Busy; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (Busy) begin
      errors++;
      $display("FAIL busy_timeout: Busy=%0b expected 0", Busy);
    end
  endtask

  // Drive one request in the slot after a posedge; entry pushed after accept.
  task automatic issue(input string nm, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic cancel, input bit waitDone);
    exp_t e;
    logic [31:0] eh, el;
    int cyc;
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL hazard_%s: request issued with Busy=%0b", nm, Busy);
    end
    En = 1'b1; MDOp = op; A = a; B = b; Cancel = cancel;
    @(posedge clk); #1;
    En = 1'b0; Cancel = 1'b0;
    if (cancel) begin
      eh = mHi; el = mLo; cyc = 0;
    end else begin
      model(op, a, b, eh, el, cyc);
    end
    mHi = eh; mLo = el;
    e.name = nm; e.hi = eh; e.lo = el; e.cycles = cyc;
    q.push_back(e);
    if (waitDone) waitIdle();
  endtask

  task automatic pushState(input string nm);
    exp_t e;
    e.name = nm; e.hi = mHi; e.lo = mLo; e.cycles = 0;
    q.push_back(e);
  endtask

  // Monitor: counts Busy cycles and retires one expected entry each time
  // the unit is idle with a result due.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busyCount = 0;
    end else if (Busy) begin
      busyCount++;
    end else if (q.size() > 0 && (q[0].cycles == 0 || busyCount > 0)) begin
      e = q.pop_front();
      check32({e.name, "_hi"}, HI, e.hi);
      check32({e.name, "_lo"}, LO, e.lo);
      check32({e.name, "_busy_cycles"}, 32'(busyCount), 32'(e.cycles));
      $display("txn %-14s HI=%08h LO=%08h busy=%0d", e.name, HI, LO, busyCount);
      busyCount = 0;
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mHi = 32'd0; mLo = 32'd0;
    pushState("reset_state");
    @(posedge clk); #1;

    issue("mult_neg",   3'd0, 32'hFFFF_FFFE, 32'd3,         1'b0, 1'b1);
    issue("multu",      3'd1, 32'hFFFF_FFFF, 32'd2,         1'b0, 1'b1);
    issue("div_neg",    3'd2, 32'hFFFF_FFF9, 32'd2,         1'b0, 1'b1);
    issue("div_ovf",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    issue("mthi",       3'd4, 32'h0000_1234, 32'd0,         1'b0, 1'b1);
    issue("mtlo",       3'd5, 32'h0000_5678, 32'd0,         1'b0, 1'b1);
    issue("divu_zero",  3'd3, 32'hDEAD_BEEF, 32'd0,         1'b0, 1'b1);
    issue("mult_cancel",3'd0, 32'h0000_0007, 32'd9,         1'b1, 1'b1);
    issue("reserved",   3'd6, 32'hAAAA_AAAA, 32'd5,         1'b0, 1'b1);

    // Cancel pulse mid-operation does not abort the multiply.
    issue("mult_midcancel", 3'd0, 32'h0001_0000, 32'h0001_0003, 1'b0, 1'b0);
    @(posedge clk); #1 Cancel = 1'b1;
    @(posedge clk); #1 Cancel = 1'b0;
    waitIdle();

    // Back-to-back: next request issued in the cycle right after completion.
    issue("b2b_first",  3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);
    issue("b2b_second", 3'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      issue($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), pick(), pick(),
            ($urandom_range(0, 7) == 0), 1'b1);
    end

    // Reset in the middle of a divide: no late write afterwards.
    issue("div_reset", 3'd3, 32'd1000, 32'd7, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    q.delete();
    @(posedge clk); #1 reset = 1'b0;
    mHi = 32'd0; mLo = 32'd0;
    pushState("reset_mid_div");
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: Busy=%0b expected 0", Busy);
    end
    repeat (12) @(posedge clk); #1;
    pushState("no_late_write");

    for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the pipelined MIPS core.
- Consumes the two register-file read operands after forwarding.
- Owns the architectural HI/LO registers, with fixed multi-cycle latency.
- Drives Busy to the hazard unit, which stalls any later mult/div/mfhi/mflo/mthi/mtlo while Start|Busy is high.

Parameters:
- MULT_CYCLES, 5, edges from accepted MULT/MULTU until HI/LO are written (must be >=1).
- DIV_CYCLES, 10, edges from accepted DIV/DIVU until HI/LO are written (must be >=1).

Ports:
- clk  input  1  core clock, all state updates on posedge.
- reset  input  1  synchronous, active-high; clears all state at the next posedge.
- En  input  1  EX-stage instruction is a mult/div/mthi/mtlo; operation code is on MDOp.
- MDOp  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved, treated as no-op.
- Cancel  input  1  exception/interrupt taken this cycle; suppresses En.
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- Busy  output  1  operation in flight.
- HI  output  32  architectural HI, read by MFHI.
- LO  output  32  architectural LO, read by MFLO.

Behaviour:
- Reset: HI=0, LO=0, Busy=0, counter=0, pending result discarded. Reset wins over every other input, including mid-operation.
- Accept condition: En && !Cancel && !Busy at a posedge.
- Requests with Busy=1 are ignored; the hazard unit guarantees none occur. The bench asserts this.
- MULT/MULTU accepted at edge E0:
  - A and B are latched, or the result is computed into pending registers.
  - Busy=1 after E0.
  - At edge E0+MULT_CYCLES: {HI,LO} <= 64-bit product and Busy <= 0.
  - Busy is high for exactly MULT_CYCLES cycles.
- MULT: signed 32x32->64. MULTU: unsigned.
- DIV/DIVU: same timing with DIV_CYCLES. LO <= quotient, HI <= remainder.
- DIV signed arithmetic:
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned.
- Divide by zero (B==0): the operation still occupies DIV_CYCLES with Busy high, and HI/LO remain unchanged at completion.
- MTHI/MTLO accepted at edge E0: HI (resp. LO) <= A at E0. Busy stays 0 and there is no latency.
- Reserved MDOp with En: no state change, Busy stays 0.
- Cancel=1: En is ignored that cycle. An operation already in flight is NOT cancelled and completes normally; the exception handler sees updated HI/LO after completion.
- HI/LO outputs are driven directly from registers; there is no bypass of an in-flight result.
- Counter: loaded with N-1 on accept, decrements while Busy. Completion when counter==0 and Busy.
- Back-to-back: a new request may be accepted at the edge immediately after the completion edge (Busy=0 in that cycle).

Decomposition:
- Shared package/header: MDOp encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO), which the decoder and hazard unit also use.
- Parameter defaults MULT_CYCLES and DIV_CYCLES also live in the package.
- Optional sub-module md_arith: combinational 64-bit product and quotient/remainder for the four ops, including the div-by-zero flag.
- md_unit keeps the sequencing (counter, Busy, pending registers, HI/LO).

Test Plan:
- Reset then MULT, A=0xFFFFFFFE (-2), B=3 -> Busy high for exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU, A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- DIV, A=0xFFFFFFF9 (-7), B=2 -> Busy for 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIV, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU with B=0 -> Busy for 10 cycles; HI and LO keep the values from the preceding MTHI 0x1234 and MTLO 0x5678.
- Cancel and reset cases:
  - MULT with Cancel=1 -> Busy stays 0, HI/LO unchanged.
  - MULT accepted, then Cancel pulses mid-operation -> completes normally.
  - DIV accepted, then reset at cycle 4 -> Busy=0, HI=LO=0 next cycle, and no late write occurs.
